// File: rtl/ev20_pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ev20_pc_sequencer_if
// Description : Bundle of the memory-fetch, decoder-issue and redirect
//               signals of the EV-20 PC sequencer.
//               master = the sequencer itself, slave = its surroundings
//               (program memory, decoder, execute stage).
// Ports       : mem_req/mem_addr/mem_ack/mem_rdata  program-memory fetch
//               ir_valid/ir_ready/ir_data/ir_pc     decoder issue
//               jump_req/call_req/ret_req/jump_addr redirects
//               halt, stack_err                     control / status
// Revision    : 1.0  initial release
// ============================================================================
interface ev20_pc_sequencer_if #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 16
);
  logic                   mem_req;
  logic [PC_WIDTH-1:0]    mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   ir_valid;
  logic                   ir_ready;
  logic [INSTR_WIDTH-1:0] ir_data;
  logic [PC_WIDTH-1:0]    ir_pc;
  logic                   jump_req;
  logic                   call_req;
  logic                   ret_req;
  logic [PC_WIDTH-1:0]    jump_addr;
  logic                   halt;
  logic                   stack_err;

  modport master (
    output mem_req, mem_addr, ir_valid, ir_data, ir_pc, stack_err,
    input  mem_ack, mem_rdata, ir_ready, jump_req, call_req, ret_req,
           jump_addr, halt
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, ir_data, ir_pc, stack_err,
    output mem_ack, mem_rdata, ir_ready, jump_req, call_req, ret_req,
           jump_addr, halt
  );
endinterface
`default_nettype wire

// File: rtl/ev20_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ev20_pc_sequencer
// Description : Program counter and instruction-fetch sequencer. Fetches one
//               word per req/ack handshake, presents it with its address on a
//               valid/ready handshake, and applies jump/call/return redirects.
// Ports       : clk, rst (sync, active-high)
//               seq : ev20_pc_sequencer_if.master (fetch, issue, redirects)
// Options     : `EV20_PC_STACK_EN enables the STACK_DEPTH-entry return-address
//               stack; without it call acts as jump, ret is ignored and
//               stack_err stays 0.
// Revision    : 1.0  initial release
// ============================================================================
module ev20_pc_sequencer #(
  parameter int                  PC_WIDTH     = 10,
  parameter int                  INSTR_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  STACK_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  ev20_pc_sequencer_if.master seq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    ir_pc_q, ir_pc_d;
  logic [INSTR_WIDTH-1:0] ir_data_q, ir_data_d;
  logic                   stack_err_q, stack_err_d;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    target;

`ifdef EV20_PC_STACK_EN
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [IDX_W-1:0]    top_idx, push_idx;

  // Only consulted when the stack is non-empty (top) or not full (push),
  // so the truncation never aliases a live entry.
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign push_idx = IDX_W'(sp_q);
`else
  logic unused_stack;
  assign unused_stack = seq.ret_req ^ (STACK_DEPTH > 0);
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_data_d   = ir_data_q;
    ir_pc_d     = ir_pc_q;
    stack_err_d = stack_err_q;
    redirect    = 1'b0;
    target      = pc_q;
`ifdef EV20_PC_STACK_EN
    stack_d     = stack_q;
    sp_d        = sp_q;
`endif

    // Redirect decode; IDLE ignores redirects entirely (no stack side effects).
    if (state_q != S_IDLE) begin
`ifdef EV20_PC_STACK_EN
      if (seq.ret_req) begin
        redirect = 1'b1;
        if (sp_q != '0) begin
          target = stack_q[top_idx];
          sp_d   = sp_q - SP_W'(1);
        end else begin
          stack_err_d = 1'b1;       // empty pop: refetch from current pc
        end
      end else if (seq.call_req) begin
        redirect = 1'b1;
        target   = seq.jump_addr;
        if (sp_q == SP_W'(STACK_DEPTH)) begin
          stack_err_d = 1'b1;       // full: drop the push, still jump
        end else begin
          stack_d[push_idx] = pc_q;
          sp_d              = sp_q + SP_W'(1);
        end
      end else if (seq.jump_req) begin
        redirect = 1'b1;
        target   = seq.jump_addr;
      end
`else
      if (seq.call_req || seq.jump_req) begin
        redirect = 1'b1;
        target   = seq.jump_addr;
      end
`endif
    end

    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (seq.mem_ack) begin
          ir_data_d = seq.mem_rdata;
          ir_pc_d   = pc_q;
          pc_d      = pc_q + PC_WIDTH'(1);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (seq.ir_ready) state_d = seq.halt ? S_HALTED : S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    // A redirect overrides everything above: a same-cycle fetch is dropped,
    // the increment is suppressed and halt has no effect.
    if (redirect) begin
      pc_d      = target;
      state_d   = S_FETCH;
      ir_data_d = ir_data_q;
      ir_pc_d   = ir_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_VECTOR;
      ir_data_q   <= '0;
      ir_pc_q     <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_data_q   <= ir_data_d;
      ir_pc_q     <= ir_pc_d;
      stack_err_q <= stack_err_d;
    end
  end

`ifdef EV20_PC_STACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      stack_q <= '{default: '0};
    end else begin
      sp_q    <= sp_d;
      stack_q <= stack_d;
    end
  end
`endif

  assign seq.mem_req   = (state_q == S_FETCH);
  assign seq.mem_addr  = pc_q;
  assign seq.ir_valid  = (state_q == S_ISSUE);
  assign seq.ir_data   = ir_data_q;
  assign seq.ir_pc     = ir_pc_q;
  assign seq.stack_err = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ev20_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ev20_pc_sequencer
// Description : Self-checking bench for ev20_pc_sequencer. Directed stimulus
//               pushes expected fetch addresses and issued {pc,data} pairs
//               into queues; a negedge monitor pops and compares them on each
//               mem handshake and each decoder transfer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ev20_pc_sequencer;
  localparam int PW = 10;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ev20_pc_sequencer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bif ();

  ev20_pc_sequencer #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_VECTOR(10'd0), .STACK_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seq(bif)
  );

  // Program memory: word = {6'h15, address}, e.g. address 0x004 -> 16'h5404.
  function automatic logic [IW-1:0] word(input logic [PW-1:0] a);
    return {6'h15, a};
  endfunction
  assign bif.mem_rdata = word(bif.mem_addr);

  int errors = 0;
  int checks = 0;

  logic [PW-1:0]    exp_fetch [$];
  logic [PW+IW-1:0] exp_issue [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [PW-1:0] a);
    exp_fetch.push_back(a);
  endtask

  task automatic push_issue(input logic [PW-1:0] a);
    exp_issue.push_back({a, word(a)});
  endtask

  // Monitor: compares every completed fetch and every decoder transfer.
  logic [PW-1:0]    m_fa;
  logic [PW+IW-1:0] m_iv;
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.mem_req && bif.mem_ack) begin
        if (exp_fetch.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected: got addr %h expected none", bif.mem_addr);
        end else begin
          m_fa = exp_fetch.pop_front();
          check("fetch_addr", 32'(bif.mem_addr), 32'(m_fa));
        end
      end
      if (bif.ir_valid && bif.ir_ready) begin
        if (exp_issue.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: got pc %h data %h expected none", bif.ir_pc, bif.ir_data);
        end else begin
          m_iv = exp_issue.pop_front();
          check("issue_pc_data", 32'({bif.ir_pc, bif.ir_data}), 32'(m_iv));
        end
      end
    end
  end

  logic [PW-1:0] tgt [5];
  logic [PW-1:0] pop_exp [4];

  initial begin
    bif.mem_ack   = 1'b1;
    bif.ir_ready  = 1'b1;
    bif.jump_req  = 1'b0;
    bif.call_req  = 1'b0;
    bif.ret_req   = 1'b0;
    bif.jump_addr = '0;
    bif.halt      = 1'b0;

    // ---- Reset state
    step(2);
    check("rst_ir_valid",  32'(bif.ir_valid),  32'd0);
    check("rst_mem_req",   32'(bif.mem_req),   32'd0);
    check("rst_ir_data",   32'(bif.ir_data),   32'd0);
    check("rst_ir_pc",     32'(bif.ir_pc),     32'd0);
    check("rst_stack_err", 32'(bif.stack_err), 32'd0);
    check("rst_mem_addr",  32'(bif.mem_addr),  32'd0);

    // ---- Sequential fetch 0..3, one instruction per 2 cycles
    for (int i = 0; i < 4; i++) begin
      push_fetch(PW'(i));
      push_issue(PW'(i));
    end
    rst = 1'b0;
    step(1);
    check("idle_then_fetch_req", 32'(bif.mem_req), 32'd1);
    check("first_fetch_addr",    32'(bif.mem_addr), 32'd0);
    step(1);
    check("first_issue_valid",   32'(bif.ir_valid), 32'd1);
    check("issue_no_req",        32'(bif.mem_req),  32'd0);
    step(6);
    bif.mem_ack = 1'b0;              // pc3 transfers now; pc4 fetch will stall
    step(1);

    // ---- Backpressure then flush by jump
    check("stall_fetch_addr", 32'(bif.mem_addr), 32'h004);
    bif.ir_ready = 1'b0;
    bif.mem_ack  = 1'b1;
    push_fetch(10'h004);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("bp_ir_valid", 32'(bif.ir_valid), 32'd1);
      check("bp_ir_data",  32'(bif.ir_data),  32'h5404);
      check("bp_mem_req",  32'(bif.mem_req),  32'd0);
      step(1);
    end
    bif.jump_req  = 1'b1;
    bif.jump_addr = 10'h020;
    push_fetch(10'h020);
    step(1);
    check("flush_ir_valid", 32'(bif.ir_valid), 32'd0);
    check("flush_mem_req",  32'(bif.mem_req),  32'd1);
    check("flush_mem_addr", 32'(bif.mem_addr), 32'h020);
    bif.jump_req = 1'b0;
    bif.ir_ready = 1'b1;
    push_issue(10'h020);
    step(1);
    step(1);

    // ---- Jump colliding with mem_ack in FETCH of 0x21
    check("pre_collide_req",  32'(bif.mem_req),  32'd1);
    check("pre_collide_addr", 32'(bif.mem_addr), 32'h021);
    bif.jump_req  = 1'b1;
    bif.jump_addr = 10'h040;
    push_fetch(10'h021);             // presented, but the word is discarded
    push_fetch(10'h040);
    push_issue(10'h040);
    step(1);
    check("collide_next_addr", 32'(bif.mem_addr), 32'h040);
    bif.jump_req = 1'b0;

    // ---- Halt on the 0x40 transfer
    bif.halt = 1'b1;
    step(2);
    bif.halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("halted_mem_req", 32'(bif.mem_req), 32'd0);
      step(1);
    end
    check("halted_ir_valid", 32'(bif.ir_valid), 32'd0);
    bif.jump_req  = 1'b1;
    bif.jump_addr = 10'h005;
    push_fetch(10'h005);
    push_issue(10'h005);
    step(1);
    check("resume_req",  32'(bif.mem_req),  32'd1);
    check("resume_addr", 32'(bif.mem_addr), 32'h005);
    bif.jump_req = 1'b0;
    step(1);
    bif.mem_ack = 1'b0;              // 0x05 transfers; 0x06 fetch stalls
    step(1);

    // ---- Wrap-around at 0x3FF
    bif.jump_req  = 1'b1;
    bif.jump_addr = 10'h3FF;
    step(1);
    bif.jump_req = 1'b0;
    bif.mem_ack  = 1'b1;
    push_fetch(10'h3FF);
    push_issue(10'h3FF);
    push_fetch(10'h000);
    push_issue(10'h000);
    step(2);
    check("wrap_fetch_req",  32'(bif.mem_req),  32'd1);
    check("wrap_fetch_addr", 32'(bif.mem_addr), 32'h000);
    step(1);
    bif.mem_ack = 1'b0;              // 0x000 transfers; 0x001 stalls
    step(1);
    check("wrap_pc_after", 32'(bif.mem_addr), 32'h001);

`ifdef EV20_PC_STACK_EN
    // ---- Return-address stack: 5 calls into a 4-deep stack, then 5 returns
    tgt     = '{10'h110, 10'h120, 10'h130, 10'h140, 10'h150};
    pop_exp = '{10'h130, 10'h120, 10'h110, 10'h001};
    for (int i = 0; i < 5; i++) begin
      bif.call_req  = 1'b1;
      bif.jump_addr = tgt[i];
      step(1);
      check("call_addr", 32'(bif.mem_addr), 32'(tgt[i]));
      check("call_stack_err", 32'(bif.stack_err), (i < 4) ? 32'd0 : 32'd1);
    end
    bif.call_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bif.ret_req = 1'b1;
      step(1);
      check("ret_addr", 32'(bif.mem_addr), 32'(pop_exp[i]));
    end
    step(1);                         // fifth return: stack empty
    check("ret_empty_addr", 32'(bif.mem_addr), 32'h001);
    check("ret_empty_err",  32'(bif.stack_err), 32'd1);
    check("ret_empty_req",  32'(bif.mem_req), 32'd1);
    bif.ret_req = 1'b0;
    bif.mem_ack = 1'b1;
    push_fetch(10'h001);
    push_issue(10'h001);
    step(2);
    bif.mem_ack = 1'b0;
    step(1);
`else
    // ---- No stack: ret ignored, call behaves as jump
    bif.mem_ack  = 1'b1;
    bif.ir_ready = 1'b0;
    push_fetch(10'h001);
    step(1);
    bif.ret_req = 1'b1;
    step(1);
    check("ret_ignored_valid", 32'(bif.ir_valid),  32'd1);
    check("ret_ignored_pc",    32'(bif.ir_pc),     32'h001);
    check("nostack_err",       32'(bif.stack_err), 32'd0);
    bif.ret_req   = 1'b0;
    bif.call_req  = 1'b1;
    bif.jump_addr = 10'h100;
    push_fetch(10'h100);
    push_issue(10'h100);
    step(1);
    check("call_as_jump_addr",  32'(bif.mem_addr), 32'h100);
    check("call_as_jump_valid", 32'(bif.ir_valid), 32'd0);
    bif.call_req = 1'b0;
    bif.ir_ready = 1'b1;
    step(1);
    bif.mem_ack = 1'b0;
    step(1);
`endif

    // ---- Scoreboard drained
    step(2);
    check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
    check("issue_queue_empty", 32'(exp_issue.size()), 32'd0);

    // ---- Reset mid-operation
    rst = 1'b1;
    step(1);
    check("rst2_mem_req",   32'(bif.mem_req),   32'd0);
    check("rst2_ir_valid",  32'(bif.ir_valid),  32'd0);
    check("rst2_mem_addr",  32'(bif.mem_addr),  32'd0);
    check("rst2_stack_err", 32'(bif.stack_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/ev20_pc_sequencer.md
# ev20_pc_sequencer

Program-counter and instruction-fetch sequencer for the EV-20 core. It holds the PC and advances it with a wrap-around increment. It fetches each instruction from program memory over a req/ack handshake and presents it, with its address, to the decoder over a valid/ready handshake. It sits between the PC-increment logic and the instruction decoder, and also applies jump, call and return redirects from the execute stage.

## Interface

Parameters:
- PC_WIDTH, 10, program-address width; PC wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 16, instruction word width.
- RESET_VECTOR, 0, PC value loaded on reset.
- STACK_DEPTH, 4, return-address stack entries (used only with PC_STACK_EN).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request to program memory.
- mem_addr  out  PC_WIDTH  fetch address; equals pc.
- mem_ack  in  1  memory returns mem_rdata this cycle; ignored unless mem_req=1.
- mem_rdata  in  INSTR_WIDTH  instruction word.
- ir_valid  out  1  ir_data/ir_pc hold a valid instruction.
- ir_ready  in  1  decoder accepts; a transfer occurs when ir_valid and ir_ready are both 1.
- ir_data  out  INSTR_WIDTH  instruction register.
- ir_pc  out  PC_WIDTH  address of ir_data.
- jump_req  in  1  redirect PC to jump_addr.
- call_req  in  1  call to jump_addr.
- ret_req  in  1  return from call.
- jump_addr  in  PC_WIDTH  redirect target.
- halt  in  1  stop fetching after the current transfer.
- stack_err  out  1  sticky overflow/underflow flag.

## Operation

- States: IDLE, FETCH, ISSUE, HALTED.
- **Reset.**
  - rst=1 forces state to IDLE and pc to RESET_VECTOR.
  - Reset values: ir_data=0, ir_pc=0, ir_valid=0, mem_req=0, stack_err=0, stack empty.
  - Reset mid-fetch or mid-issue discards everything.
- **IDLE:** mem_req=0; always moves to FETCH on the next clock.
- **FETCH:**
  - mem_req=1, mem_addr=pc.
  - On mem_ack: ir_data<=mem_rdata, ir_pc<=pc, pc<=pc+1 (truncated to PC_WIDTH, so all-ones wraps to 0), then go to ISSUE.
  - Without mem_ack: stay in FETCH.
- **ISSUE:**
  - ir_valid=1, mem_req=0; ir_data and ir_pc stay stable until the transfer.
  - On transfer: go to HALTED if halt=1, else go to FETCH.
- **HALTED:** mem_req=0, ir_valid=0; leaves only on a redirect or on reset.
- **Redirect** (any of ret_req, call_req, jump_req):
  - Priority when asserted together: ret_req > call_req > jump_req.
  - Accepted in FETCH, ISSUE and HALTED; ignored in IDLE.
  - Effect: pc<=target, state<=FETCH, ir_valid<=0.
- **Redirect vs. a fetch completing:** a redirect beats a same-cycle mem_ack. The fetched word is discarded and the PC increment is suppressed.
- **Redirect in ISSUE:**
  - With ir_ready=1, the transfer counts as completed.
  - With ir_ready=0, the held instruction is flushed.
  - halt is ignored whenever a redirect occurs.
- **Return-address stack** (with PC_STACK_EN):
  - call_req pushes the current pc, which is the address after the last fetched instruction, and loads jump_addr.
  - ret_req pops into pc.
  - Push when full: push dropped, jump still taken, stack_err<=1.
  - Pop when empty: pc unchanged, refetch from pc, stack_err<=1.
  - stack_err clears only on reset.

## Timing

- First mem_req=1 occurs in the second cycle after rst deasserts (the IDLE cycle comes first).
- mem_ack in the same cycle as mem_req captures at that edge; ir_valid=1 in the following cycle.
- With mem_ack and ir_ready held at 1, the block sustains one instruction per 2 cycles.
- Redirect asserted at edge N: mem_req=1 with mem_addr=target in cycle N+1.
- All outputs are registered or decoded from state only. No input-to-output combinational path exists except mem_addr following pc.

## Configuration

- Macro: `EV20_PC_STACK_EN`.
- **Defined:** STACK_DEPTH-entry return-address stack; call_req and ret_req behave as described in Operation.
- **Undefined:**
  - No stack storage.
  - call_req behaves exactly like jump_req.
  - ret_req is ignored and causes no redirect.
  - stack_err is tied to 0.

## Test plan

- **Reset and sequential fetch:** rst for 2 cycles, mem_ack=1, ir_ready=1 held → mem_addr runs 0,1,2,3; each ir_pc matches its address; ir_valid on alternate cycles.
- **Wrap-around:** PC_WIDTH=4, jump to 15, then one fetch → ir_pc=15 and the next mem_addr is 0.
- **Backpressure and flush:** ir_ready=0 for 5 cycles → ir_data stable and mem_req=0. Then jump_req to 0x20 with ir_ready=0 → ir_valid=0 next cycle and mem_addr=0x20.
- **Jump/ack collision:** mem_ack and jump_req(0x40) in the same cycle → fetched word never appears on ir_data; next fetch is at 0x40, not pc+1.
- **Halt:** halt=1 during a transfer → HALTED, mem_req stays 0 for 10 cycles. jump_req(0x05) → fetch resumes at 0x05.
- **Stack (EV20_PC_STACK_EN):**
  - STACK_DEPTH=4; 5 calls → fifth call sets stack_err=1 but still jumps.
  - 4 returns → pops come back in LIFO order.
  - 5th return → pc unchanged and stack_err stays 1.
  - Without the macro → ret_req causes no redirect and stack_err=0.
